// File: rtl/wdg_timer_ctrl.sv
// Watchdog down-counter with prescaler: reloads, prescales and decrements
// the timeout counter for the watchdog FSM, and counts stage-1 expiries.
module wdg_timer_ctrl #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned PRESC_W = 16,
  parameter int unsigned STAT_W  = 8
) (
  input  logic               clk,
  input  logic               res,
  input  logic [CNT_W-1:0]   timeout0,
  input  logic [CNT_W-1:0]   timeout1,
  input  logic [PRESC_W-1:0] presc_div,
  input  logic               do_cnt,
  input  logic               s1wto,
  input  logic               kick,
  input  logic               dbg_halt,
  input  logic               stat_clr,
  output logic               count0,
  output logic [CNT_W-1:0]   cnt_val,
  output logic               presc_tick,
  output logic [STAT_W-1:0]  s1_exp_cnt
);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [STAT_W-1:0]  stat_q, stat_d;
  logic               s1wto_q;
  logic [CNT_W-1:0]   lv;
  logic               tick_raw;
  logic               s1_edge;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt_q       <= '0;
      presc_cnt_q <= '0;
      stat_q      <= '0;
      s1wto_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      presc_cnt_q <= presc_cnt_d;
      stat_q      <= stat_d;
      s1wto_q     <= s1wto;
    end
  end

  always_comb begin
    lv          = s1wto ? timeout1 : timeout0;
    // >= so a lowered presc_div fires immediately instead of wrapping
    tick_raw    = (presc_cnt_q >= presc_div);
    cnt_d       = cnt_q;
    presc_cnt_d = presc_cnt_q;
    if (kick) begin
      cnt_d       = timeout0;
      presc_cnt_d = '0;
    end else if (!do_cnt) begin
      cnt_d       = lv;
      presc_cnt_d = '0;
    end else if (!dbg_halt) begin
      if (tick_raw) begin
        presc_cnt_d = '0;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end else begin
        presc_cnt_d = presc_cnt_q + PRESC_W'(1);
      end
    end
  end

  always_comb begin
    s1_edge = s1wto & ~s1wto_q;
    stat_d  = stat_q;
    if (stat_clr) begin
      stat_d = s1_edge ? STAT_W'(1) : '0;
    end else if (s1_edge && (stat_q != '1)) begin
      stat_d = stat_q + STAT_W'(1);
    end
  end

  // Strobes are gated by res so they read 0 the moment reset asserts.
  assign presc_tick = do_cnt & ~kick & ~dbg_halt & tick_raw & ~res;
  assign count0     = do_cnt & (cnt_q == '0) & ~res;
  assign cnt_val    = cnt_q;
  assign s1_exp_cnt = stat_q;

endmodule
